interpolating_lut_prog_streamer: RTL and testbench

Transmit side of the interpolating LUT programming interface. It holds a software-written shadow table of 2**G_ADDR_WIDTH entries. On a start pulse it streams the whole table, index 0 upward, as a valid/ready stream into the LUT core's lut_prog_din port. It then waits for the core's done flag and reports completion, or a timeout, to the control plane.

---
 rtl/interpolating_lut_pkg.sv | 20 ++
 rtl/lut_shadow_ram.sv | 40 ++++
 rtl/interpolating_lut_prog_streamer.sv | 170 +++++++++++++++++
 tb/tb_interpolating_lut_prog_streamer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interpolating_lut_pkg.sv
// Shared types and default geometry for the interpolating LUT core and its
// programming streamer.
package interpolating_lut_pkg;

  localparam int LUT_ADDR_WIDTH = 10;
  localparam int LUT_DWIDTH     = 24;

  typedef enum logic [1:0] {
    SM_IDLE      = 2'd0,
    SM_FETCH     = 2'd1,
    SM_SEND      = 2'd2,
    SM_WAIT_DONE = 2'd3
  } prog_state_t;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int timeout_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/lut_shadow_ram.sv
// Software-written shadow copy of the LUT: simple dual-port RAM with a
// registered read port. Array contents are deliberately not reset.
module lut_shadow_ram
  import interpolating_lut_pkg::*;
#(
  parameter int G_ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int G_DWIDTH     = LUT_DWIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wr_en,
  input  logic [G_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [G_DWIDTH-1:0]     i_wr_data,
  input  logic                    i_rd_en,
  input  logic [G_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [G_DWIDTH-1:0]     o_rd_data
);

  logic [G_DWIDTH-1:0] r_mem [0:(2**G_ADDR_WIDTH)-1];
  logic [G_DWIDTH-1:0] r_rd_data;

  // Write port into the storage array.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register holds its value between reads so the stream stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= {G_DWIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/interpolating_lut_prog_streamer.sv
// Streams the shadow table into the LUT core's programming port on start,
// then waits for the core's done flag or a timeout.
module interpolating_lut_prog_streamer
  import interpolating_lut_pkg::*;
#(
  parameter int G_ADDR_WIDTH     = LUT_ADDR_WIDTH,
  parameter int G_DWIDTH         = LUT_DWIDTH,
  parameter int G_TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr,
  input  logic [G_DWIDTH-1:0]     wr_data,
  input  logic                    wr_en,
  output logic                    wr_reject,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [G_DWIDTH-1:0]     prog_dout,
  output logic                    prog_dout_valid,
  input  logic                    prog_dout_ready,
  input  logic                    prog_done_in
);

  localparam int                      CNT_W    = timeout_cnt_width(G_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(G_TIMEOUT_CYCLES - 1);
  localparam logic [G_ADDR_WIDTH-1:0] IDX_LAST = {G_ADDR_WIDTH{1'b1}};

  prog_state_t             r_state;
  prog_state_t             w_state_nxt;
  logic [G_ADDR_WIDTH-1:0] r_index;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    r_busy;
  logic                    r_valid;
  logic                    r_done;
  logic                    r_timeout_err;
  logic                    r_wr_reject;
  logic                    w_wr_accept;
  logic                    w_rd_en;
  logic                    w_start_accept;
  logic                    w_beat_adv;
  logic                    w_enter_wait;
  logic                    w_set_done;
  logic                    w_set_timeout;
  logic                    w_cnt_inc;

  assign w_wr_accept = wr_en && (r_state == SM_IDLE);
  assign w_rd_en     = (r_state == SM_FETCH);

  lut_shadow_ram #(
    .G_ADDR_WIDTH (G_ADDR_WIDTH),
    .G_DWIDTH     (G_DWIDTH)
  ) u_shadow_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_accept),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_index),
    .o_rd_data (prog_dout)
  );

  // Next-state decode; enable low forces an immediate return to idle.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_accept = 1'b0;
    w_beat_adv     = 1'b0;
    w_enter_wait   = 1'b0;
    w_set_done     = 1'b0;
    w_set_timeout  = 1'b0;
    w_cnt_inc      = 1'b0;
    if (enable) begin
      case (r_state)
        SM_IDLE: begin
          if (start) begin
            w_start_accept = 1'b1;
            w_state_nxt    = SM_FETCH;
          end else begin
            w_state_nxt = SM_IDLE;
          end
        end
        SM_FETCH: begin
          w_state_nxt = SM_SEND;
        end
        SM_SEND: begin
          if (prog_dout_ready) begin
            if (r_index == IDX_LAST) begin
              w_enter_wait = 1'b1;
              w_state_nxt  = SM_WAIT_DONE;
            end else begin
              w_beat_adv  = 1'b1;
              w_state_nxt = SM_FETCH;
            end
          end else begin
            w_state_nxt = SM_SEND;
          end
        end
        SM_WAIT_DONE: begin
          // Core done takes priority over a simultaneous timeout.
          if (prog_done_in) begin
            w_set_done  = 1'b1;
            w_state_nxt = SM_IDLE;
          end else if (r_wait_cnt == CNT_LAST) begin
            w_set_timeout = 1'b1;
            w_state_nxt   = SM_IDLE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = SM_WAIT_DONE;
          end
        end
        default: begin
          w_state_nxt = SM_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = SM_IDLE;
    end
  end

  // State, index, timeout counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SM_IDLE;
      r_index       <= {G_ADDR_WIDTH{1'b0}};
      r_wait_cnt    <= {CNT_W{1'b0}};
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wr_reject   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != SM_IDLE);
      r_valid     <= (w_state_nxt == SM_SEND);
      r_wr_reject <= wr_en && (r_state != SM_IDLE);
      if (w_start_accept) begin
        r_index       <= {G_ADDR_WIDTH{1'b0}};
        r_done        <= 1'b0;
        r_timeout_err <= 1'b0;
      end else if (w_beat_adv) begin
        r_index <= r_index + G_ADDR_WIDTH'(1);
      end else begin
        r_index <= r_index;
      end
      if (w_enter_wait) begin
        r_wait_cnt <= {CNT_W{1'b0}};
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign busy            = r_busy;
  assign prog_dout_valid = r_valid;
  assign done            = r_done;
  assign timeout_err     = r_timeout_err;
  assign wr_reject       = r_wr_reject;

endmodule

// File: tb/tb_interpolating_lut_prog_streamer.sv
// Randomized bench for the LUT programming streamer with a table-level model
// of what each pass must deliver.
module tb_interpolating_lut_prog_streamer;

  localparam int AW = 4;
  localparam int DW = 24;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          start = 1'b0;
  logic          prog_dout_ready = 1'b0;
  logic          prog_done_in = 1'b0;
  logic          wr_reject;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [DW-1:0] prog_dout;
  logic          prog_dout_valid;

  int            passed = 0;
  int            total = 0;
  int            cyc = 0;
  int            last_cyc = 0;
  int            beat_total = 0;
  int            pass_base = 0;
  int            rej_cnt = 0;
  bit            full_rate = 1'b0;
  bit            hold_pending = 1'b0;
  bit            prev_en = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [DW-1:0] exp_d;
  logic [DW-1:0] model_mem [N];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_data [0:1023];

  interpolating_lut_prog_streamer #(
    .G_ADDR_WIDTH     (AW),
    .G_DWIDTH         (DW),
    .G_TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_en           (wr_en),
    .wr_reject       (wr_reject),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .prog_dout       (prog_dout),
    .prog_dout_valid (prog_dout_valid),
    .prog_dout_ready (prog_dout_ready),
    .prog_done_in    (prog_done_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Compare process: every accepted beat against the model, and stability under backpressure.
  always @(negedge clk) begin
    if (hold_pending && prev_en && !reset) begin
      check("hold_valid", {31'd0, prog_dout_valid}, 32'd1);
      check("hold_data", {8'd0, prog_dout}, {8'd0, held_data});
    end
    hold_pending = 1'b0;
    if (!reset && prog_dout_valid) begin
      if (prog_dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got 0x%0h with no entry pending", prog_dout);
        end else begin
          exp_d = exp_q.pop_front();
          check("beat_data", {8'd0, prog_dout}, {8'd0, exp_d});
        end
        if (full_rate && beat_total > pass_base)
          check("beat_rate", cyc - last_cyc, 32'd2);
        last_cyc = cyc;
        got_data[beat_total] = prog_dout;
        beat_total++;
      end else begin
        hold_pending = 1'b1;
        held_data    = prog_dout;
      end
    end
    prev_en = enable && !reset;
    if (wr_reject) rej_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // A start snapshots the whole table (after any same-cycle write) as the expected stream.
  task automatic do_start(input bit with_write, input logic [AW-1:0] a, input logic [DW-1:0] d);
    start = 1'b1;
    if (with_write) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model_mem[a] = d;
    end
    for (int i = 0; i < N; i++) exp_q.push_back(model_mem[i]);
    pass_base = beat_total;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_stream(input int pct, input int upto);
    int n = 0;
    while ((beat_total - pass_base) < upto && n < 600) begin
      prog_dout_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end
    check("stream_beats", beat_total - pass_base, upto);
  endtask

  task automatic finish_done();
    tick();
    prog_done_in = 1'b1;
    tick();
    prog_done_in = 1'b0;
    check("done_set", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_terr", {31'd0, timeout_err}, 32'd0);
    check("done_valid", {31'd0, prog_dout_valid}, 32'd0);
    check("model_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int r0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, prog_dout_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_reject", {31'd0, wr_reject}, 32'd0);
    check("rst_dout", {8'd0, prog_dout}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Basic pass at full rate.
    for (int i = 0; i < N; i++) write_entry(AW'(i), DW'(i * 16));
    full_rate = 1'b1;
    do_start(1'b0, '0, '0);
    run_stream(100, N);
    check("basic_beat0", {8'd0, got_data[pass_base]}, 32'h000);
    check("basic_beat5", {8'd0, got_data[pass_base + 5]}, 32'h050);
    check("basic_beat15", {8'd0, got_data[pass_base + 15]}, 32'h0F0);
    finish_done();

    // Random backpressure.
    full_rate = 1'b0;
    do_start(1'b0, '0, '0);
    run_stream(30, N);
    finish_done();

    // Write while busy is dropped and flagged once.
    full_rate = 1'b1;
    r0 = rej_cnt;
    do_start(1'b0, '0, '0);
    run_stream(100, 5);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'hABC;
    tick();
    wr_en = 1'b0;
    run_stream(100, N);
    check("reject_pulses", rej_cnt - r0, 32'd1);
    finish_done();
    do_start(1'b0, '0, '0);
    run_stream(100, N);
    check("entry3_kept", {8'd0, got_data[pass_base + 3]}, 32'h030);
    finish_done();

    // Enable drop in the middle of a pass.
    do_start(1'b0, '0, '0);
    run_stream(100, 8);
    prog_dout_ready = 1'b0;
    tick();
    check("drop_pre_valid", {31'd0, prog_dout_valid}, 32'd1);
    enable = 1'b0;
    tick();
    check("drop_valid", {31'd0, prog_dout_valid}, 32'd0);
    check("drop_busy", {31'd0, busy}, 32'd0);
    check("drop_done", {31'd0, done}, 32'd0);
    check("drop_terr", {31'd0, timeout_err}, 32'd0);
    exp_q.delete();
    enable = 1'b1;
    do_start(1'b0, '0, '0);
    run_stream(100, N);
    check("restart_beat0", {8'd0, got_data[pass_base]}, 32'h000);
    check("restart_beat1", {8'd0, got_data[pass_base + 1]}, 32'h010);
    finish_done();

    // Timeout after eight idle cycles in the wait state.
    do_start(1'b0, '0, '0);
    run_stream(100, N);
    repeat (7) tick();
    check("to_early_terr", {31'd0, timeout_err}, 32'd0);
    check("to_early_busy", {31'd0, busy}, 32'd1);
    tick();
    check("to_terr", {31'd0, timeout_err}, 32'd1);
    check("to_done", {31'd0, done}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);

    // Random table, with a write landing on the start cycle.
    for (int i = 0; i < N; i++) write_entry(AW'(i), DW'($urandom));
    ra = AW'($urandom_range(0, N - 1));
    rd = DW'($urandom);
    full_rate = 1'b0;
    do_start(1'b1, ra, rd);
    check("restart_terr_clr", {31'd0, timeout_err}, 32'd0);
    check("restart_done_clr", {31'd0, done}, 32'd0);
    run_stream(50, N);
    finish_done();

    // Asynchronous reset between edges while a beat is presented.
    full_rate = 1'b1;
    do_start(1'b0, '0, '0);
    run_stream(100, 3);
    prog_dout_ready = 1'b0;
    tick();
    check("ar_pre_valid", {31'd0, prog_dout_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", {31'd0, prog_dout_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_done", {31'd0, done}, 32'd0);
    check("ar_terr", {31'd0, timeout_err}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Shadow table survives reset.
    do_start(1'b0, '0, '0);
    run_stream(100, N);
    finish_done();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
